ps2_scancode_rx: RTL and testbench



---
 rtl/ps2_scancode_rx_pkg.sv | 22 ++
 rtl/ps2_scancode_rx_if.sv | 29 ++
 rtl/ps2_scancode_rx_sync_edge.sv | 35 +++
 rtl/ps2_scancode_rx.sv | 154 +++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_scancode_rx_pkg.sv
// Shared types and constants for the PS/2 receive path: FSM states, prefix codes, frame geometry.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  localparam int PS2_FRAME_LEN = 11;
  localparam int PS2_DATA_BITS = 8;

  // True when the eight data bits plus the parity bit carry an odd number of ones.
  function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// PS/2 keyboard bus pins plus the decoded scan-code outputs seen by the colour decoder.
interface ps2_scancode_rx_if;

  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] ps2Code;
  logic       codeStrobe;
  logic       extended;
  logic       frameError;

  modport master (
    output ps2Clk,
    output ps2Data,
    input  ps2Code,
    input  codeStrobe,
    input  extended,
    input  frameError
  );

  modport slave (
    input  ps2Clk,
    input  ps2Data,
    output ps2Code,
    output codeStrobe,
    output extended,
    output frameError
  );

endinterface

// File: rtl/ps2_scancode_rx_sync_edge.sv
// Synchronises raw ps2Clk/ps2Data into clk and flags the falling edge of the PS/2 clock.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2Clk,
  input  logic ps2Data,
  output logic syncData,
  output logic fallEdge
);

  logic [SYNC_STAGES-1:0] clkSync;
  logic [SYNC_STAGES-1:0] dataSync;
  logic                   clkPrev;
  logic                   syncClk;

  // Flops reset to the idle bus level so reset itself never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkSync  <= '1;
      dataSync <= '1;
      clkPrev  <= 1'b1;
    end else begin
      clkSync  <= {clkSync[SYNC_STAGES-2:0], ps2Clk};
      dataSync <= {dataSync[SYNC_STAGES-2:0], ps2Data};
      clkPrev  <= syncClk;
    end
  end

  assign syncClk  = clkSync[SYNC_STAGES-1];
  assign syncData = dataSync[SYNC_STAGES-1];
  assign fallEdge = clkPrev & ~syncClk;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix handling and partial-frame timeout.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input logic               clk,
  input logic               reset,
  ps2_scancode_rx_if.slave  bus
);

  ps2_state_e      state, stateNxt;
  logic [2:0]      bitCnt;
  logic [7:0]      shreg;
  logic [TO_W-1:0] toCnt;
  logic            breakPending, extPending;
  logic            fallEdge, dataS;
  logic            parOk, timeout;
  logic            startErr, frameValid, frameBad, isExt, isBreak;
  logic            strobeEv, errEv;
  logic [7:0]      code_p1;
  logic            ext_p1, strobe_p1, err_p1;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2Clk   (bus.ps2Clk),
    .ps2Data  (bus.ps2Data),
    .syncData (dataS),
    .fallEdge (fallEdge)
  );

`ifdef PS2_PARITY_CHECK_EN
  logic parBit;

  always_ff @(posedge clk) begin
    if (fallEdge && state == PARITY) parBit <= dataS;
  end

  assign parOk = ps2_odd_parity_ok(shreg, parBit);
`else
  assign parOk = 1'b1;
`endif

  // A fall edge in the same cycle wins over an expiring timeout.
  assign timeout = (state != IDLE) && !fallEdge && (toCnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    if (fallEdge) begin
      case (state)
        IDLE:    if (!dataS) stateNxt = DATA;
        DATA:    if (bitCnt == 3'd7) stateNxt = PARITY;
        PARITY:  stateNxt = STOP;
        STOP:    stateNxt = IDLE;
        default: stateNxt = IDLE;
      endcase
    end else if (timeout) begin
      stateNxt = IDLE;
    end
  end

  always_comb begin
    startErr   = 1'b0;
    frameValid = 1'b0;
    frameBad   = 1'b0;
    if (fallEdge) begin
      case (state)
        IDLE:    startErr = dataS;
        STOP: begin
          frameValid = dataS && parOk;
          frameBad   = !(dataS && parOk);
        end
        default: ;
      endcase
    end
    isExt    = (shreg == PS2_EXT_PREFIX);
    isBreak  = (shreg == PS2_BREAK_PREFIX);
    strobeEv = frameValid && !isExt && !isBreak && !breakPending;
    errEv    = startErr || frameBad || timeout;
  end

  // Stage 0: deserialiser and inter-edge watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      bitCnt <= 3'd0;
      toCnt  <= '0;
    end else begin
      if (fallEdge && state == IDLE)      bitCnt <= 3'd0;
      else if (fallEdge && state == DATA) bitCnt <= bitCnt + 3'd1;

      if (fallEdge || state == IDLE) toCnt <= '0;
      else                           toCnt <= toCnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fallEdge && state == DATA) shreg <= {dataS, shreg[7:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      breakPending <= 1'b0;
      extPending   <= 1'b0;
    end else if (timeout) begin
      breakPending <= 1'b0;
      extPending   <= 1'b0;
    end else if (frameValid) begin
      if (isExt) begin
        extPending <= 1'b1;
      end else if (isBreak) begin
        breakPending <= 1'b1;
      end else if (breakPending) begin
        breakPending <= 1'b0;
        extPending   <= 1'b0;
      end else begin
        extPending <= 1'b0;
      end
    end
  end

  // Stage 1: registered code, prefix flag and event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      code_p1   <= 8'h00;
      ext_p1    <= 1'b0;
      strobe_p1 <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      strobe_p1 <= strobeEv;
      err_p1    <= errEv;
      if (strobeEv) begin
        code_p1 <= shreg;
        ext_p1  <= extPending;
      end
    end
  end

  assign bus.ps2Code    = code_p1;
  assign bus.extended   = ext_p1;
  assign bus.codeStrobe = strobe_p1;
  assign bus.frameError = err_p1;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: expected strobes/errors queued at stimulus, checked on output.
module tb_ps2_scancode_rx;

  localparam int TO   = 200;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ps2_scancode_rx_if bus();

  ps2_scancode_rx #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.ps2Data = b;
    wait_clk(HALF);
    bus.ps2Clk = 1'b0;
    wait_clk(HALF);
    bus.ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic parflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    send_bit((~^c) ^ parflip);
    send_bit(1'b1);
    bus.ps2Data = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic push_code(input logic [7:0] c, input logic e);
    exp_t x;
    x.kind = 0;
    x.code = c;
    x.ext  = e;
    sb.push_back(x);
  endtask

  task automatic push_err();
    exp_t x;
    x.kind = 1;
    x.code = 8'h00;
    x.ext  = 1'b0;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && (bus.codeStrobe === 1'b1 || bus.frameError === 1'b1)) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
      end else begin
        e.kind = 2;
        e.code = 8'h00;
        e.ext  = 1'b0;
      end
      chk("both_high", {31'd0, bus.codeStrobe & bus.frameError}, 32'd0);
      chk("event_kind", bus.frameError ? 32'd1 : 32'd0, e.kind);
      if (e.kind == 0 && bus.codeStrobe === 1'b1) begin
        chk("code", {24'd0, bus.ps2Code}, {24'd0, e.code});
        chk("ext", {31'd0, bus.extended}, {31'd0, e.ext});
      end
    end
  end

  initial begin
    logic [7:0] c;
    bus.ps2Clk  = 1'b1;
    bus.ps2Data = 1'b1;
    reset       = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(1);
    chk("rst_code", {24'd0, bus.ps2Code}, 32'h00);
    chk("rst_ext", {31'd0, bus.extended}, 32'd0);
    chk("rst_strobe", {31'd0, bus.codeStrobe}, 32'd0);
    chk("rst_ferr", {31'd0, bus.frameError}, 32'd0);

    // plain make code
    push_code(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("t1_hold", {24'd0, bus.ps2Code}, 32'h1C);

    // release sequence swallowed, then next make
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("t2_keep", {24'd0, bus.ps2Code}, 32'h1C);
    push_code(8'h24, 1'b0);
    send_frame(8'h24, 1'b0);
    chk("t2_new", {24'd0, bus.ps2Code}, 32'h24);

    // extended prefix
    send_frame(8'hE0, 1'b0);
    push_code(8'h75, 1'b1);
    send_frame(8'h75, 1'b0);
    chk("t3_ext_set", {31'd0, bus.extended}, 32'd1);
    push_code(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("t3_ext_clr", {31'd0, bus.extended}, 32'd0);

    // wrong parity
`ifdef PS2_PARITY_CHECK_EN
    push_err();
`else
    push_code(8'h1C, 1'b0);
`endif
    send_frame(8'h1C, 1'b1);

    // partial frame then bus stall
    c = 8'h1C;
    push_err();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c[i]);
    bus.ps2Data = 1'b1;
    wait_clk(TO + 10);
    push_code(8'h24, 1'b0);
    send_frame(8'h24, 1'b0);
    chk("t5_code", {24'd0, bus.ps2Code}, 32'h24);

    // reset mid-frame, bus tail must only raise errors
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c[i]);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(1);
    chk("t6_rst_code", {24'd0, bus.ps2Code}, 32'h00);
    chk("t6_rst_ext", {31'd0, bus.extended}, 32'd0);
    chk("t6_rst_strobe", {31'd0, bus.codeStrobe}, 32'd0);
    chk("t6_rst_ferr", {31'd0, bus.frameError}, 32'd0);
    push_err();
    push_err();
    for (int i = 4; i < 8; i++) send_bit(c[i]);
    send_bit(~^c);
    send_bit(1'b1);
    bus.ps2Data = 1'b1;
    wait_clk(TO + 10);
    chk("t6_after_tail", {24'd0, bus.ps2Code}, 32'h00);
    push_code(8'h2D, 1'b0);
    send_frame(8'h2D, 1'b0);
    chk("t6_code", {24'd0, bus.ps2Code}, 32'h2D);

    wait_clk(20);
    chk("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
